tdes_round_ctrl: RTL and testbench
==================================

TDES_ROUND_CTRL -- requirements
Module: tdes_round_ctrl

Interface
REQ-001 Parameter: NUM_ROUNDS, default 16, DES rounds per stage.
REQ-002 Parameter: NUM_STAGES, default 3, cipher stages per block (EDE).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to process one block; accepted only when ready=1.
REQ-006 decrypt  input  1  mode, sampled with accepted start: 0 = E(K1)-D(K2)-E(K3), 1 = D(K3)-E(K2)-D(K1).
REQ-007 abort  input  1  synchronous cancel of the block in progress.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 load_data  output  1  one-cycle pulse to capture the input block and initial permutation.
REQ-010 round_en  output  1  datapath performs one Feistel round this cycle.
REQ-011 round  output  4  current round index, 0..NUM_ROUNDS-1.
REQ-012 stage  output  2  current stage index, 0..NUM_STAGES-1.
REQ-013 key_sel  output  2  key in use: 0=K1, 1=K2, 2=K3.
REQ-014 dir  output  1  key-schedule direction: 0 = left shift (encrypt), 1 = right shift (decrypt).
REQ-015 shift_amt  output  2  key rotate amount applied this round.
REQ-016 last_round  output  1  high on round NUM_ROUNDS-1; datapath suppresses L/R swap.
REQ-017 done  output  1  one-cycle pulse; the output block is valid.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, ROUND, STAGE_END and DONE.
REQ-019 IDLE -> LOAD when start=1 and abort=0; decrypt latched into a mode register at that edge.
REQ-020 LOAD lasts 1 cycle: load_data=1, stage=0, round=0; then -> ROUND.
REQ-021 ROUND: round_en=1; round increments by 1 per cycle from 0 to NUM_ROUNDS-1.
REQ-022 At round NUM_ROUNDS-1: -> STAGE_END if stage<NUM_STAGES-1, else -> DONE; round wraps to 0.
REQ-023 STAGE_END lasts 1 cycle: round_en=0, stage increments, key registers reload; then -> ROUND.
REQ-024 DONE lasts 1 cycle: done=1; then -> IDLE.
REQ-025 Latency: done is high exactly 52 cycles after the edge that accepts start (1 LOAD + 48 ROUND + 2 STAGE_END + 1 DONE).
REQ-026 dir = mode XOR (stage==1).
REQ-027 key_sel, mode 0: stages 0,1,2 -> K1,K2,K3; mode 1: stages 0,1,2 -> K3,K2,K1.
REQ-028 shift_amt with dir=0: rounds 0,1,8,15 -> 1; all other rounds -> 2.
REQ-029 shift_amt with dir=1: round 0 -> 0; rounds 1,8,15 -> 1; all other rounds -> 2.
REQ-030 start while ready=0 SHALL be ignored; it does not queue.
REQ-031 abort=1 in any non-IDLE state -> IDLE next cycle; counters clear; no done pulse.
REQ-032 abort and start high together in IDLE: abort wins and the block is not accepted.
REQ-033 abort in the DONE cycle: the done pulse still completes; next state is IDLE.
REQ-034 Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-035 round_en, load_data, done and last_round are mutually exclusive, except last_round, which is only high together with round_en.

Reset
REQ-036 rst=1: state=IDLE, ready=1, round=0, stage=0, mode=0, key_sel=0, dir=0, shift_amt=0; load_data, round_en, last_round and done are 0.
REQ-037 rst asserted mid-block: the block is discarded immediately; no done pulse follows reset release.

Structure
REQ-038 Package tdes_pkg holds the state enum, key_sel encodings (KEY1/KEY2/KEY3), NUM_ROUNDS/NUM_STAGES defaults and the shift tables.
REQ-039 Sub-module tdes_round_cnt: 4-bit up-counter with enable, synchronous clear, wrap value input and a registered terminal flag; stage counter and FSM stay in tdes_round_ctrl.

Verification
REQ-040 rst, then start=1, decrypt=0 for 1 cycle -> load_data at cycle 1, round_en cycles 2-17 with key_sel=0 and dir=0, STAGE_END at 18, key_sel=1 and dir=1 at cycles 19-34, key_sel=2 at 36-51, done at cycle 52, ready at 53.
REQ-041 decrypt=1 block -> key_sel 2,1,0 across stages; dir 1,0,1; stage-0 shift_amt sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-042 start pulsed at cycles 10 and 30 after an accepted start -> both ignored; exactly one done, at cycle 52.
REQ-043 abort at cycle 20 -> IDLE and ready=1 at cycle 21, no done; a new start at cycle 22 -> done 52 cycles later.
REQ-044 rst asserted at cycle 40 for 2 cycles -> all outputs at reset values during reset; no done afterwards.
REQ-045 start and abort together in IDLE -> no load_data; ready stays 1.

Source files
------------

// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - shared states, key encodings and shift tables for the TDES round sequencer
package tdes_pkg;

  localparam int NUM_ROUNDS_DEF = 16;
  localparam int NUM_STAGES_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    STAGE_END,
    DONE
  } tdes_state_e;

  localparam logic [1:0] KEY1 = 2'd0;
  localparam logic [1:0] KEY2 = 2'd1;
  localparam logic [1:0] KEY3 = 2'd2;

  // Index 15 is the leftmost entry; decrypt skips the rotate on round 0.
  localparam logic [15:0][1:0] SHIFT_ENC = {2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
                                            2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
  localparam logic [15:0][1:0] SHIFT_DEC = {2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
                                            2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};

  function automatic logic [1:0] shift_lookup(input logic dir, input logic [3:0] rnd);
    return dir ? SHIFT_DEC[rnd] : SHIFT_ENC[rnd];
  endfunction

  function automatic logic [1:0] key_for_stage(input logic mode, input logic [1:0] stage);
    logic [1:0] key;
    case (stage)
      2'd0:    key = mode ? KEY3 : KEY1;
      2'd1:    key = KEY2;
      default: key = mode ? KEY1 : KEY3;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/tdes_round_cnt.sv
// rtl/tdes_round_cnt.sv - round counter with wrap value and a terminal flag aligned to the count
module tdes_round_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] wrap,
  output logic [3:0] count,
  output logic       term
);

  logic [3:0] count_d, count_q;
  logic       term_d, term_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (en) begin
      count_d = (count_q == wrap) ? 4'd0 : count_q + 4'd1;
    end
    term_d = (count_d == wrap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
      term_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      term_q  <= term_d;
    end
  end

  assign count = count_q;
  assign term  = term_q;

endmodule

// File: rtl/tdes_round_ctrl.sv
// rtl/tdes_round_ctrl.sv - sequences LOAD, 3x16 Feistel rounds and DONE for one EDE/DED block
module tdes_round_ctrl
  import tdes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  input  logic       abort,
  output logic       ready,
  output logic       load_data,
  output logic       round_en,
  output logic [3:0] round,
  output logic [1:0] stage,
  output logic [1:0] key_sel,
  output logic       dir,
  output logic [1:0] shift_amt,
  output logic       last_round,
  output logic       done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

  tdes_state_e state_d, state_q;
  logic [1:0]  stage_d, stage_q;
  logic        mode_d, mode_q;
  logic        ready_d, ready_q;
  logic        load_data_d, load_data_q;
  logic        round_en_d, round_en_q;
  logic        done_d, done_q;
  logic [1:0]  key_sel_d, key_sel_q;
  logic        dir_d, dir_q;
  logic [3:0]  cnt_round;
  logic        cnt_term;

  // Counter only runs in ROUND; any other state (or abort) parks it at zero.
  tdes_round_cnt u_round_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == ROUND),
    .clr   (abort || (state_q != ROUND)),
    .wrap  (LAST_ROUND),
    .count (cnt_round),
    .term  (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          mode_d  = decrypt;
        end
      end
      LOAD:      state_d = ROUND;
      ROUND: begin
        if (cnt_term) begin
          if (stage_q < LAST_STAGE) begin
            state_d = STAGE_END;
            stage_d = stage_q + 2'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      STAGE_END: state_d = ROUND;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
    if (state_d == IDLE) begin
      stage_d = 2'd0;
    end
    ready_d     = (state_d == IDLE);
    load_data_d = (state_d == LOAD);
    round_en_d  = (state_d == ROUND);
    done_d      = (state_d == DONE);
    key_sel_d   = (state_d == IDLE) ? KEY1 : key_for_stage(mode_d, stage_d);
    dir_d       = (state_d != IDLE) && (mode_d ^ (stage_d == 2'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= 2'd0;
      mode_q      <= 1'b0;
      ready_q     <= 1'b1;
      load_data_q <= 1'b0;
      round_en_q  <= 1'b0;
      done_q      <= 1'b0;
      key_sel_q   <= KEY1;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      mode_q      <= mode_d;
      ready_q     <= ready_d;
      load_data_q <= load_data_d;
      round_en_q  <= round_en_d;
      done_q      <= done_d;
      key_sel_q   <= key_sel_d;
      dir_q       <= dir_d;
    end
  end

  assign ready      = ready_q;
  assign load_data  = load_data_q;
  assign round_en   = round_en_q;
  assign round      = cnt_round;
  assign stage      = stage_q;
  assign key_sel    = key_sel_q;
  assign dir        = dir_q;
  assign shift_amt  = round_en_q ? shift_lookup(dir_q, cnt_round) : 2'd0;
  assign last_round = round_en_q && cnt_term;
  assign done       = done_q;

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// tb/tb_tdes_round_ctrl.sv - directed bench with a cycle-offset model of the TDES round sequencer
module tb_tdes_round_ctrl;

  localparam int R     = 16;
  localparam int S     = 3;
  localparam int TOTAL = 1 + S * R + (S - 1) + 1;

  logic       clk = 1'b0;
  logic       rst, start, decrypt, abort;
  logic       ready, load_data, round_en, dir, last_round, done;
  logic [3:0] round;
  logic [1:0] stage, key_sel, shift_amt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int m_busy = 0;
  int m_k = 0;
  int m_mode = 0;

  int load_cnt, load_at, done_cnt, done_at, ready_at;
  int first_k[4];
  int last_k[4];
  int key_of_stage[4];
  int dir_of_stage[4];
  logic [31:0] stage0_shift;

  tdes_round_ctrl #(.NUM_ROUNDS(R), .NUM_STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .decrypt    (decrypt),
    .abort      (abort),
    .ready      (ready),
    .load_data  (load_data),
    .round_en   (round_en),
    .round      (round),
    .stage      (stage),
    .key_sel    (key_sel),
    .dir        (dir),
    .shift_amt  (shift_amt),
    .last_round (last_round),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc - base, act, exp);
    end
  endtask

  task automatic clear_rec();
    load_cnt = 0; load_at = -1; done_cnt = 0; done_at = -1; ready_at = 0;
    stage0_shift = '0;
    for (int i = 0; i < 4; i++) begin
      first_k[i] = -1; last_k[i] = -1; key_of_stage[i] = -1; dir_of_stage[i] = -1;
    end
  endtask

  task automatic compare();
    int j, st, pos, ek, ed, es;
    bit is_load, is_round, is_done;
    if (rst) begin
      chk("rst_ready", ready, 1);       chk("rst_round", round, 0);
      chk("rst_stage", stage, 0);       chk("rst_key_sel", key_sel, 0);
      chk("rst_dir", dir, 0);           chk("rst_shift", shift_amt, 0);
      chk("rst_load", load_data, 0);    chk("rst_round_en", round_en, 0);
      chk("rst_last", last_round, 0);   chk("rst_done", done, 0);
    end else if (m_busy == 0) begin
      chk("idle_ready", ready, 1);      chk("idle_load", load_data, 0);
      chk("idle_round_en", round_en, 0); chk("idle_done", done, 0);
      chk("idle_last", last_round, 0);
    end else begin
      is_load = (m_k == 1);
      is_done = (m_k == TOTAL);
      st = 0; pos = 0;
      if (!is_load) begin
        j = m_k - 2; st = j / (R + 1); pos = j % (R + 1);
      end
      is_round = !is_load && (pos < R);
      chk("busy_ready", ready, 0);
      chk("load_data", load_data, int'(is_load));
      chk("round_en", round_en, int'(is_round));
      chk("done", done, int'(is_done));
      chk("last_round", last_round, int'(is_round && pos == R - 1));
      if (is_load) begin
        chk("load_round", round, 0);
        chk("load_stage", stage, 0);
      end
      if (is_round) begin
        ek = (m_mode != 0) ? (S - 1 - st) : st;
        ed = (m_mode != 0) ^ (st == 1);
        if (pos == 0)                              es = ed ? 0 : 1;
        else if (pos == 1 || pos == 8 || pos == 15) es = 1;
        else                                       es = 2;
        chk("round", round, pos);
        chk("stage", stage, st);
        chk("key_sel", key_sel, ek);
        chk("dir", dir, ed);
        chk("shift_amt", shift_amt, es);
      end
    end
  endtask

  task automatic record();
    int rel;
    rel = cyc - base;
    if (load_data) begin load_cnt++; load_at = rel; end
    if (done) begin done_cnt++; done_at = rel; end
    if (ready && rel >= 2 && ready_at == 0) ready_at = rel;
    if (round_en) begin
      if (first_k[key_sel] < 0) first_k[key_sel] = rel;
      last_k[key_sel] = rel;
      key_of_stage[stage] = key_sel;
      dir_of_stage[stage] = dir;
      if (stage == 2'd0) stage0_shift[int'(round) * 2 +: 2] = shift_amt;
    end
  endtask

  task automatic tick();
    logic s_start, s_abort, s_dec, s_rst;
    s_start = start; s_abort = abort; s_dec = decrypt; s_rst = rst;
    @(posedge clk);
    if (s_rst) begin
      m_busy = 0; m_k = 0;
    end else if (m_busy != 0) begin
      if (s_abort || m_k == TOTAL) begin m_busy = 0; m_k = 0; end
      else m_k++;
    end else if (s_start && !s_abort) begin
      m_busy = 1; m_k = 1; m_mode = int'(s_dec);
    end
    #2;
    cyc++;
    compare();
    record();
  endtask

  task automatic run_to(input int n);
    while (cyc - base < n) tick();
  endtask

  task automatic start_block(input logic dec);
    base = cyc;
    clear_rec();
    decrypt = dec; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0;
    clear_rec();
    repeat (3) tick();
    chk("reset_ready_literal", ready, 1);
    rst = 1'b0;
    repeat (2) tick();

    // Encrypt block: cycle map pinned by hand
    start_block(1'b0);
    run_to(60);
    chk("enc_load_at", load_at, 1);
    chk("enc_k1_first", first_k[0], 2);   chk("enc_k1_last", last_k[0], 17);
    chk("enc_k2_first", first_k[1], 19);  chk("enc_k2_last", last_k[1], 34);
    chk("enc_k3_first", first_k[2], 36);  chk("enc_k3_last", last_k[2], 51);
    chk("enc_dir_s0", dir_of_stage[0], 0);
    chk("enc_dir_s1", dir_of_stage[1], 1);
    chk("enc_dir_s2", dir_of_stage[2], 0);
    chk("enc_done_at", done_at, 52);
    chk("enc_done_cnt", done_cnt, 1);
    chk("enc_ready_at", ready_at, 53);

    // Decrypt block
    start_block(1'b1);
    run_to(60);
    chk("dec_key_s0", key_of_stage[0], 2);
    chk("dec_key_s1", key_of_stage[1], 1);
    chk("dec_key_s2", key_of_stage[2], 0);
    chk("dec_dir_s0", dir_of_stage[0], 1);
    chk("dec_dir_s1", dir_of_stage[1], 0);
    chk("dec_dir_s2", dir_of_stage[2], 1);
    chk("dec_shift_seq", int'(stage0_shift), int'(32'h6AA9_AAA4));
    chk("dec_done_at", done_at, 52);

    // Starts while busy are dropped
    start_block(1'b0);
    run_to(10); start = 1'b1; tick(); start = 1'b0;
    run_to(30); start = 1'b1; tick(); start = 1'b0;
    run_to(60);
    chk("busy_start_loads", load_cnt, 1);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_done_at", done_at, 52);

    // Abort mid-block, then restart
    start_block(1'b0);
    run_to(20); abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_ready_c21", ready, 1);
    run_to(22);
    chk("abort_no_done", done_cnt, 0);
    start_block(1'b0);
    run_to(60);
    chk("restart_done_at", done_at, 52);
    chk("restart_done_cnt", done_cnt, 1);

    // Reset mid-block
    start_block(1'b1);
    run_to(40);
    rst = 1'b1;
    #1;
    chk("rst_async_round_en", round_en, 0);
    chk("rst_async_ready", ready, 1);
    tick(); tick();
    rst = 1'b0;
    run_to(100);
    chk("rst_no_done", done_cnt, 0);

    // start and abort together in IDLE
    base = cyc; clear_rec();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    chk("sa_no_load", load_cnt, 0);
    chk("sa_ready", ready, 1);

    // Abort during DONE still lets the pulse complete
    start_block(1'b0);
    run_to(52); abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_done_cnt", done_cnt, 1);
    chk("abort_done_ready", ready, 1);
    run_to(58);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
